// File: rtl/hypot_seq_ctrl_pkg.sv
// Shared types and default widths for the hypotenuse sequencer.
// Optional feature macro: HYPOT_ROUND_EN (round-to-nearest result).
package hypot_pkg;

  // Default operand width and the widths that follow from it.
  localparam int W_DEF  = 8;
  localparam int RW_DEF = W_DEF + 1;      // root / result width
  localparam int AW_DEF = 2 * W_DEF + 1;  // accumulator width, holds a^2 + b^2
  localparam int KW_DEF = $clog2(W_DEF + 1);  // root bit-index width

  // ROUND is only visited when HYPOT_ROUND_EN is defined.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SQ_A  = 3'd1,
    SQ_B  = 3'd2,
    ROOT  = 3'd3,
    ROUND = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/hypot_seq_ctrl_if.sv
// Request/response bus of the hypotenuse sequencer.
// Handshake rule: a transfer happens on a rising clk edge where valid and
// ready are both high; the sender holds its data stable until that edge.
interface hypot_seq_ctrl_if #(parameter int W = 8);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   result;
  logic         busy;

  // Requester / result consumer side.
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  // Sequencer side.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );

endinterface

// File: rtl/hypot_seq_ctrl_sq_unit.sv
// Combinational unsigned squarer built from shifted partial products.
module sq_unit #(
  parameter int RW = 9
) (
  input  logic [RW-1:0]   x,
  output logic [2*RW-1:0] y
);

  // Sum x << i for every set bit i of x.
  always_comb begin
    logic [2*RW-1:0] xe;
    xe = {{RW{1'b0}}, x};
    y  = '0;
    for (int i = 0; i < RW; i++) begin
      if (x[i]) y = y + (xe << i);
    end
  end

endmodule

// File: rtl/hypot_seq_ctrl.sv
// Multi-cycle floor(sqrt(a^2 + b^2)) sequencer sharing one squarer.
// Optional feature macro: HYPOT_ROUND_EN adds a ROUND state that turns the
// floor root into a round-to-nearest root.
module hypot_seq_ctrl
  import hypot_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  hypot_seq_ctrl_if.slave    bus,
  output state_t             state_dbg
);

  localparam int RW = W + 1;
  localparam int AW = 2 * W + 1;
  localparam int KW = $clog2(W + 1);

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [AW-1:0]   acc;
  logic [RW-1:0]   root;
  logic [KW-1:0]   k;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            busy_q;
  logic [RW-1:0]   result_q;

  logic [RW-1:0]   trial;
  logic [RW-1:0]   sq_x;
  logic [2*RW-1:0] sq_y;
  logic            trial_fits;
  logic [RW-1:0]   root_step;

  sq_unit #(.RW(RW)) u_sq (
    .x (sq_x),
    .y (sq_y)
  );

  // Candidate root for this bit, and the squarer operand chosen by state.
  always_comb begin
    trial = root | (RW'(1) << k);
    sq_x  = '0;
    case (state)
      SQ_A:    sq_x = {1'b0, a_q};
      SQ_B:    sq_x = {1'b0, b_q};
      ROOT:    sq_x = trial;
      ROUND:   sq_x = root;
      default: sq_x = '0;
    endcase
    trial_fits = (sq_y <= {{(2*RW-AW){1'b0}}, acc});
    root_step  = trial_fits ? trial : root;
  end

  // Sequencer FSM; all handshake outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc         <= '0;
      root        <= '0;
      k           <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= SQ_A;
          end
        end
        SQ_A: begin
          acc   <= sq_y[AW-1:0];
          state <= SQ_B;
        end
        SQ_B: begin
          acc   <= acc + sq_y[AW-1:0];
          root  <= '0;
          k     <= KW'(W);
          state <= ROOT;
        end
        ROOT: begin
          root <= root_step;
          if (k == '0) begin
`ifdef HYPOT_ROUND_EN
            state <= ROUND;
`else
            result_q    <= root_step;
            out_valid_q <= 1'b1;
            state       <= DONE;
`endif
          end else begin
            k <= k - KW'(1);
          end
        end
`ifdef HYPOT_ROUND_EN
        ROUND: begin
          // root^2 <= acc always holds here, so the remainder cannot wrap.
          if ((acc - sq_y[AW-1:0]) > {{(AW-RW){1'b0}}, root}) begin
            root     <= root + RW'(1);
            result_q <= root + RW'(1);
          end else begin
            result_q <= root;
          end
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
`endif
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.result    = result_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_hypot_seq_ctrl.sv
// Bench for hypot_seq_ctrl: directed cases, backpressure, mid-run reset and
// a randomized back-to-back stream checked against an integer sqrt model.
module tb_hypot_seq_ctrl;
  import hypot_pkg::*;

  localparam int W  = 8;
  localparam int RW = W + 1;
`ifdef HYPOT_ROUND_EN
  localparam int LAT = W + 4;
`else
  localparam int LAT = W + 3;
`endif

  logic   clk;
  logic   rst;
  state_t state_dbg;

  hypot_seq_ctrl_if #(.W(W)) bus ();

  hypot_seq_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  logic [RW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int ref_hyp(input int a, input int b);
    int s;
    int r;
    s = a * a + b * b;
    r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
`ifdef HYPOT_ROUND_EN
    if (s - r * r > r) r++;
`endif
    return r;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  // The transfer happens at the next rising edge when both are high here.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        logic [RW-1:0] e;
        e = exp_q.pop_front();
        check("result", int'(bus.result), int'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and wait for its handshake; keep=1 leaves in_valid high.
  task automatic issue(input int a, input int b, input bit keep);
    bit done;
    bit rdy;
    done = 1'b0;
    bus.a = W'(a);
    bus.b = W'(b);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      rdy = bus.in_ready;
      step();
      if (rdy) begin
        exp_q.push_back(RW'(ref_hyp(a, b)));
        done = 1'b1;
      end
    end
    if (!done) check("issue_timeout", 0, 1);
    if (!keep) bus.in_valid = 1'b0;
  endtask

  // Called right after the accepting edge: count edges until out_valid.
  task automatic wait_out(input bit check_lat);
    int n;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      check("in_ready_low_while_busy", int'(bus.in_ready), 0);
      step();
      n++;
    end
    if (check_lat) check("latency", n, LAT);
    else if (n >= 100) check("out_timeout", 0, 1);
  endtask

  task automatic run_one(input int a, input int b);
    issue(a, b, 1'b0);
    wait_out(1'b1);
    step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    step();
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_result", int'(bus.result), 0);
    check("rst_state", int'(state_dbg), int'(IDLE));
    step();
    rst = 1'b0;
    step();

    // Directed values, each with a latency check.
    run_one(3, 4);
    run_one(255, 255);
    run_one(0, 0);
    run_one(2, 3);
    run_one(5, 5);

    // Backpressure: stall the consumer, poke in a request that must be ignored.
    bus.out_ready = 1'b0;
    issue(7, 24, 1'b0);
    wait_out(1'b0);
    bus.a = 8'd1;
    bus.b = 8'd1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("stall_out_valid", int'(bus.out_valid), 1);
      check("stall_result", int'(bus.result), ref_hyp(7, 24));
      check("stall_in_ready", int'(bus.in_ready), 0);
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("after_pulse_out_valid", int'(bus.out_valid), 0);
    check("after_pulse_in_ready", int'(bus.in_ready), 1);
    bus.out_ready = 1'b1;
    run_one(1, 1);

    // Reset while the root search is running abandons the request.
    issue(9, 9, 1'b0);
    repeat (4) step();
    check("pre_rst_state_root", int'(state_dbg), int'(ROOT));
    rst = 1'b1;
    step();
    exp_q.delete();
    check("mid_rst_in_ready", int'(bus.in_ready), 1);
    check("mid_rst_out_valid", int'(bus.out_valid), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_result", int'(bus.result), 0);
    rst = 1'b0;
    step();
    run_one(6, 8);

    // Back-to-back random stream with in_valid and out_ready held high.
    for (int i = 0; i < 100; i++) begin
      issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b1);
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
    check("drain_pending", exp_q.size(), 0);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
